// File: rtl/tree_adder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tree_adder_pkg
// Purpose  : Shared definitions for the tree-adder family: sequencer state
//            encoding, slice-width and index-width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package tree_adder_pkg;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One slice position is reserved for the carry-in, so a slice adds
  // ADDER_SIZE-1 operand bits.
  function automatic int slice_w(input int adder_size);
    return adder_size - 1;
  endfunction

  // Width of the slice index counter
  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/brent_kung.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : brent_kung
// Purpose  : Parallel-prefix adder slice. Operands are ADDER_SIZE-1 bits; the
//            carry-in occupies prefix position 0. Bits are ripple-combined
//            inside groups of GROUP_SIZE, and group generate/propagate terms
//            are combined by a Brent-Kung tree of at most LEV levels (any
//            remaining span is chained across tree blocks).
// Revision : 1.0 - initial release
// ============================================================================
module brent_kung #(
  parameter int ADDER_SIZE = 16,
  parameter int GROUP_SIZE = 4,
  parameter int LEV        = 3
) (
  input  logic [ADDER_SIZE-2:0] a,
  input  logic [ADDER_SIZE-2:0] b,
  input  logic                  cin,
  output logic [ADDER_SIZE-2:0] sum,
  output logic                  cout
);

  localparam int c_NG  = ADDER_SIZE / GROUP_SIZE;
  localparam int c_GL  = ($clog2(c_NG) < LEV) ? $clog2(c_NG) : LEV;
  localparam int c_BLK = 1 << c_GL;

  logic [ADDER_SIZE-1:0] w_gen;
  logic [ADDER_SIZE-1:0] w_prop;
  logic [ADDER_SIZE-1:0] w_lg;
  logic [ADDER_SIZE-1:0] w_lp;
  logic [c_NG-1:0]       w_tg;
  logic [c_NG-1:0]       w_tp;
  logic [ADDER_SIZE-1:1] w_carry;

  // Bit-level generate/propagate; position 0 carries cin as a pure generate
  assign w_gen  = {a & b, cin};
  assign w_prop = {a ^ b, 1'b0};

  // Ripple prefix from each group's first bit up to every bit in the group
  always_comb begin
    w_lg = '0;
    w_lp = '0;
    for (int g = 0; g < c_NG; g++) begin
      for (int k = 0; k < GROUP_SIZE; k++) begin
        if (k == 0) begin
          w_lg[g*GROUP_SIZE] = w_gen[g*GROUP_SIZE];
          w_lp[g*GROUP_SIZE] = w_prop[g*GROUP_SIZE];
        end else begin
          w_lg[g*GROUP_SIZE+k] = w_gen[g*GROUP_SIZE+k] |
                                 (w_prop[g*GROUP_SIZE+k] & w_lg[g*GROUP_SIZE+k-1]);
          w_lp[g*GROUP_SIZE+k] = w_prop[g*GROUP_SIZE+k] & w_lp[g*GROUP_SIZE+k-1];
        end
      end
    end
  end

  // Brent-Kung tree over groups: up-sweep, chain across blocks, down-sweep
  always_comb begin
    w_tg = '0;
    w_tp = '0;
    for (int g = 0; g < c_NG; g++) begin
      w_tg[g] = w_lg[g*GROUP_SIZE+GROUP_SIZE-1];
      w_tp[g] = w_lp[g*GROUP_SIZE+GROUP_SIZE-1];
    end
    for (int l = 0; l < c_GL; l++) begin
      for (int i = 0; i < c_NG; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          w_tg[i] = w_tg[i] | (w_tp[i] & w_tg[i-(1<<l)]);
          w_tp[i] = w_tp[i] & w_tp[i-(1<<l)];
        end
      end
    end
    for (int k = 2; k <= c_NG / c_BLK; k++) begin
      w_tg[k*c_BLK-1] = w_tg[k*c_BLK-1] | (w_tp[k*c_BLK-1] & w_tg[k*c_BLK-1-c_BLK]);
      w_tp[k*c_BLK-1] = w_tp[k*c_BLK-1] & w_tp[k*c_BLK-1-c_BLK];
    end
    for (int l = c_GL - 1; l >= 0; l--) begin
      for (int i = 0; i < c_NG; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          w_tg[i] = w_tg[i] | (w_tp[i] & w_tg[i-(1<<l)]);
          w_tp[i] = w_tp[i] & w_tp[i-(1<<l)];
        end
      end
    end
  end

  // Carry into each bit: group-local prefix seeded by the previous group's carry
  always_comb begin
    w_carry = '0;
    for (int p = 1; p < ADDER_SIZE; p++) begin
      if ((p % GROUP_SIZE) == 0) begin
        w_carry[p] = w_tg[p/GROUP_SIZE-1];
      end else if (p < GROUP_SIZE) begin
        w_carry[p] = w_lg[p-1];
      end else begin
        w_carry[p] = w_lg[p-1] | (w_lp[p-1] & w_tg[p/GROUP_SIZE-1]);
      end
    end
  end

  assign sum  = w_prop[ADDER_SIZE-1:1] ^ w_carry;
  assign cout = w_tg[c_NG-1];

endmodule
`default_nettype wire

// File: rtl/bk_wide_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bk_wide_add_seq
// Purpose  : Wide adder that reuses one brent_kung slice over WORDS cycles,
//            least-significant slice first, with a registered carry chain.
//            Valid/ready on both sides, one operation in flight.
// Options  : BK_SEQ_SUB_EN - adds in_sub; when set, computes A-B.
// Revision : 1.0 - initial release
// ============================================================================
module bk_wide_add_seq
  import tree_adder_pkg::*;
#(
  parameter int ADDER_SIZE = 16,
  parameter int GROUP_SIZE = 4,
  parameter int LEV        = 3,
  parameter int WORDS      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WORDS*slice_w(ADDER_SIZE)-1:0]   in_a,
  input  logic [WORDS*slice_w(ADDER_SIZE)-1:0]   in_b,
  input  logic                                   in_cin,
`ifdef BK_SEQ_SUB_EN
  input  logic                                   in_sub,
`endif
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORDS*slice_w(ADDER_SIZE)-1:0]   out_sum,
  output logic                                   out_cout
);

  localparam int c_W  = slice_w(ADDER_SIZE);
  localparam int c_N  = WORDS * c_W;
  localparam int c_IW = idx_w(WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [c_N-1:0]    r_a;
  logic [c_N-1:0]    r_b;
  logic              r_carry;
  logic [c_IW-1:0]   r_idx;
  logic [c_N-1:0]    r_sum;
  logic              r_cout;

  logic              w_accept;
  logic              w_last;
  logic [c_N-1:0]    w_b_load;
  logic              w_cin_load;
  logic [c_W-1:0]    w_sa;
  logic [c_W-1:0]    w_sb;
  logic [c_W-1:0]    w_ssum;
  logic              w_scout;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == c_IW'(WORDS - 1));

`ifdef BK_SEQ_SUB_EN
  // Subtraction is A + ~B + 1; the caller's carry-in is ignored in that mode
  assign w_b_load   = in_sub ? ~in_b : in_b;
  assign w_cin_load = in_sub ? 1'b1 : in_cin;
`else
  assign w_b_load   = in_b;
  assign w_cin_load = in_cin;
`endif

  // Operand slice selected by the running index
  assign w_sa = r_a[r_idx*c_W +: c_W];
  assign w_sb = r_b[r_idx*c_W +: c_W];

  brent_kung #(
    .ADDER_SIZE (ADDER_SIZE),
    .GROUP_SIZE (GROUP_SIZE),
    .LEV        (LEV)
  ) u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .sum  (w_ssum),
    .cout (w_scout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; no new request is taken in the DONE->IDLE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice per cycle into the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= w_b_load;
      r_carry <= w_cin_load;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*c_W +: c_W] <= w_ssum;
      r_carry                 <= w_scout;
      r_idx                   <= r_idx + c_IW'(1);
      if (w_last) begin
        r_cout <= w_scout;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bk_wide_add_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bk_wide_add_seq
// Purpose  : Self-checking bench for bk_wide_add_seq: directed and random
//            operands against an integer-arithmetic reference, backpressure
//            and asynchronous reset mid-operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bk_wide_add_seq;

  localparam int ADDER_SIZE = 16;
  localparam int GROUP_SIZE = 4;
  localparam int LEV        = 3;
  localparam int WORDS      = 4;
  localparam int N          = WORDS * (ADDER_SIZE - 1);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
`ifdef BK_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bk_wide_add_seq #(
    .ADDER_SIZE (ADDER_SIZE),
    .GROUP_SIZE (GROUP_SIZE),
    .LEV        (LEV),
    .WORDS      (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef BK_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    return N'({$urandom, $urandom});
  endfunction

  // Reference: plain wide-integer arithmetic, bit N is the carry out
  function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic cin, input logic sub);
    logic [N:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    return r;
  endfunction

  // Runs one operation from IDLE; optionally leaves it parked in DONE
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                       input logic sub, input logic release_it, input string tag);
    logic [N:0] exp;
    int cyc;
    exp = ref_result(a, b, cin, sub);
    in_a = a;
    in_b = b;
    in_cin = cin;
`ifdef BK_SEQ_SUB_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = rnd_word();
    in_b = rnd_word();
    in_cin = ~cin;
    check({tag, "_ready_busy"}, 64'(in_ready), 64'd0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(WORDS));
    check({tag, "_sum"}, 64'(out_sum), 64'(exp[N-1:0]));
    check({tag, "_cout"}, 64'(out_cout), 64'(exp[N]));
    if (release_it) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
    end
  endtask

  initial begin
    logic [N-1:0] held;
    logic [N-1:0] ones;
    ones = '1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
`ifdef BK_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_cout", 64'(out_cout), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op(N'(60'h1E0), N'(60'h00F), 1'b0, 1'b0, 1'b1, "basic");
    do_op(N'(60'h7FFF), N'(60'h1), 1'b0, 1'b0, 1'b1, "slice_carry");
    do_op(N'(60'h3FFFFFFF), N'(60'h1), 1'b0, 1'b0, 1'b1, "slice2_carry");
    do_op(ones, '0, 1'b1, 1'b0, 1'b1, "full_ripple");
    do_op(ones, ones, 1'b1, 1'b0, 1'b1, "all_ones");

    for (int i = 0; i < 20; i++) begin
      do_op(rnd_word(), rnd_word(), 1'($urandom), 1'b0, 1'b1, $sformatf("rand%0d", i));
    end

    // Backpressure: result frozen, new requests ignored while DONE
    do_op(N'(60'hFEDCBA987654321), N'(60'h123456789ABCDEF), 1'b0, 1'b0, 1'b0, "bp");
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = rnd_word();
      in_b = rnd_word();
      tick();
      check($sformatf("bp_hold%0d", i), 64'({in_ready, out_valid}), 64'b01);
      check($sformatf("bp_sum%0d", i), 64'(out_sum), 64'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", 64'({in_ready, out_valid}), 64'b10);
    repeat (WORDS + 1) tick();
    check("bp_no_accept", 64'({in_ready, out_valid}), 64'b10);

    // Asynchronous reset with two slices already written
    in_a = N'(60'h0AB_CDE0_1234_5678);
    in_b = '0;
    in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_partial_nonzero", 64'(out_sum != '0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_hs", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_op(N'(5), N'(7), 1'b0, 1'b0, 1'b1, "after_rst");

`ifdef BK_SEQ_SUB_EN
    do_op(N'(5), N'(7), 1'b0, 1'b1, 1'b1, "sub_borrow");
    do_op(N'(7), N'(5), 1'b1, 1'b1, 1'b1, "sub_noborrow");
    for (int i = 0; i < 8; i++) begin
      do_op(rnd_word(), rnd_word(), 1'($urandom), 1'b1, 1'b1, $sformatf("sub_rand%0d", i));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bk_wide_add_seq.md
# bk_wide_add_seq

Multi-cycle sequencer that performs one wide addition using a single `brent_kung` slice. Each operand is split into WORDS slices of ADDER_SIZE-1 bits, and the sequencer feeds one slice per clock, least-significant slice first, through the slice. The carry-out of each slice is registered and becomes the carry-in of the next slice. The block sits between a valid/ready producer and a valid/ready consumer, so a wide datapath can reuse one tree-adder instance instead of instantiating WORDS of them.

## Interface
- ADDER_SIZE, 16: passed to `brent_kung`; slice width W = ADDER_SIZE-1 = 15.
- GROUP_SIZE, 4: passed to `brent_kung`.
- LEV, 3: passed to `brent_kung`.
- WORDS, 4: number of slices; operand width N = WORDS*W = 60. Legal range is 2..16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_cin  in  1  initial carry.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  N  result.
- out_cout  out  1  carry out of the top slice.
- in_sub  in  1  only present with BK_SEQ_SUB_EN; selects A-B.

## Operation
- States:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after the slice with idx == WORDS-1 is computed.
  - DONE → IDLE on `out_ready`.
- On accept:
  - Latch in_a and in_b into operand registers.
  - Set carry_q = in_cin and idx = 0.
  - Clear out_sum.
- In RUN, each cycle:
  - Drive the slice with A = a_q[idx*W +: W], B = b_q[idx*W +: W], cin = carry_q.
  - On the edge, write the slice sum into out_sum[idx*W +: W], set carry_q = slice cout, and increment idx.
- Entering DONE: out_cout = final carry_q, out_valid = 1.
- out_sum and out_cout are stable while out_valid is high. Input-side signals are ignored outside IDLE.
- No overlap of operations. in_ready is 0 in RUN and DONE, even in the cycle where out_ready is accepted.
- Arithmetic is modulo 2^N. out_cout is bit N of A+B+cin.
- Reset (asserted at any time, including mid-RUN):
  - State returns to IDLE.
  - The in-flight result is discarded.
  - All registers clear.
- Reset values:
  - in_ready = 1.
  - out_valid = 0.
  - out_sum = 0.
  - out_cout = 0.
  - idx = 0, carry_q = 0.

## Timing
- Accept edge is cycle 0. Slices are computed in cycles 1..WORDS. out_valid rises on the edge ending cycle WORDS, i.e. WORDS cycles after the accept edge.
- Minimum initiation interval: WORDS+2 cycles (accept, WORDS slices, one DONE cycle with out_ready=1).
- The critical path is one slice plus the idx-based operand mux. There is no combinational path from in_* to out_*.
- out_ready held low keeps the block in DONE indefinitely with outputs frozen.

## Configuration
- BK_SEQ_SUB_EN defined:
  - Adds port in_sub, latched on accept.
  - When in_sub = 1, b_q is stored as ~in_b and carry_q starts at 1 (in_cin is ignored), so out_sum = A-B mod 2^N.
  - out_cout = 1 means no borrow (A >= B).
- BK_SEQ_SUB_EN undefined: the port and the inversion logic are absent, and the block only adds.

## Structure
- Shared package `tree_adder_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the slice-width function W = ADDER_SIZE-1;
  - the idx width function clog2(WORDS).
- One sub-module: the existing `brent_kung` instance, parameterized with ADDER_SIZE, GROUP_SIZE, LEV. Everything else is in this module.

## Test plan
- Reset release, then A=0x1E0, B=0x00F, cin=0: out_valid 4 cycles after accept, out_sum=0x1EF, out_cout=0.
- Cross-slice carry, A=0x7FFF, B=0x1, cin=0: out_sum=0x8000 (carry into slice 1), out_cout=0. Also A=0x3FFFFFFF, B=1: out_sum=0x40000000.
- Full ripple, A=2^60-1, B=0, cin=1: out_sum=0, out_cout=1. Also A=B=2^60-1, cin=1: out_sum=2^60-1, out_cout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles: out_valid and out_sum stay frozen, in_ready stays 0.
  - A new in_valid during that time is not accepted.
  - Raise out_ready: IDLE on the next edge, in_ready=1.
- Reset mid-op:
  - Assert rst_n=0 in RUN with idx=2: outputs clear immediately and asynchronously.
  - After release, A=5, B=7 yields out_sum=12 with no trace of the aborted operation.
- With BK_SEQ_SUB_EN defined:
  - A=5, B=7, in_sub=1: out_sum=2^60-2, out_cout=0.
  - A=7, B=5: out_sum=2, out_cout=1.
